// File: rtl/digital_clock_pkg.sv
// rtl/digital_clock_pkg.sv - shared widths, limits, time record and load check for the hms clock
package digital_clock_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HR24_MAX = 23;
    localparam int HR12_MAX = 12;
    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HR_W     = 5;

    typedef struct packed {
        logic [HR_W-1:0]  hours;
        logic [MIN_W-1:0] minutes;
        logic [SEC_W-1:0] seconds;
        logic             pm;
    } clk_time_t;

    function automatic logic time_valid(clk_time_t t, bit mode_12h);
        logic hr_ok;
        if (mode_12h) begin
            hr_ok = (t.hours >= HR_W'(1)) && (t.hours <= HR_W'(HR12_MAX));
        end else begin
            hr_ok = (t.hours <= HR_W'(HR24_MAX));
        end
        return hr_ok && (t.minutes <= MIN_W'(MIN_MAX)) && (t.seconds <= SEC_W'(SEC_MAX));
    endfunction

endpackage

// File: rtl/clock_prescaler.sv
// rtl/clock_prescaler.sv - divides clk to a one-cycle tick every CLK_PER_SEC running cycles
module clock_prescaler #(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_SEC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = run && (cnt_q == CNT_LAST);

    // clear restarts the second phase even when the counter is frozen
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digital_clock_hms.sv
// rtl/digital_clock_hms.sv - hours/minutes/seconds timekeeper with 12h/24h mode, load and alarm
module digital_clock_hms
    import digital_clock_pkg::*;
#(
    parameter int CLK_PER_SEC = 50_000_000,
    parameter int MODE_12H    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 load,
    input  logic [HR_W-1:0]      load_hours,
    input  logic [MIN_W-1:0]     load_minutes,
    input  logic [SEC_W-1:0]     load_seconds,
    input  logic                 load_pm,
    input  logic                 alarm_en,
    input  logic [HR_W-1:0]      alarm_hours,
    input  logic [MIN_W-1:0]     alarm_minutes,
    input  logic                 alarm_pm,
    output logic [SEC_W-1:0]     seconds,
    output logic [MIN_W-1:0]     minutes,
    output logic [HR_W-1:0]      hours,
    output logic                 pm,
    output logic                 sec_tick,
    output logic                 alarm,
    output logic                 load_err
);

    localparam bit IS_12H = (MODE_12H != 0);
    localparam logic [HR_W-1:0] HR_RESET = IS_12H ? HR_W'(HR12_MAX) : '0;

    clk_time_t time_q, time_d;
    clk_time_t load_time;
    clk_time_t adv_time;
    logic      sec_tick_q, sec_tick_d;
    logic      alarm_q, alarm_d;
    logic      load_err_q, load_err_d;
    logic      tick;
    logic      load_ok;
    logic      alarm_match;

    clock_prescaler #(
        .CLK_PER_SEC(CLK_PER_SEC)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clear (load_ok),
        .tick  (tick)
    );

    always_comb begin
        load_time.hours   = load_hours;
        load_time.minutes = load_minutes;
        load_time.seconds = load_seconds;
        load_time.pm      = IS_12H ? load_pm : 1'b0;
        load_ok           = load && time_valid(load_time, IS_12H);
    end

    // carry chain: every field wraps by comparison against its own limit
    always_comb begin
        adv_time = time_q;
        if (time_q.seconds == SEC_W'(SEC_MAX)) begin
            adv_time.seconds = '0;
            if (time_q.minutes == MIN_W'(MIN_MAX)) begin
                adv_time.minutes = '0;
                if (IS_12H) begin
                    if (time_q.hours == HR_W'(HR12_MAX)) begin
                        adv_time.hours = HR_W'(1);
                    end else begin
                        adv_time.hours = time_q.hours + HR_W'(1);
                        if (time_q.hours == HR_W'(HR12_MAX - 1)) begin
                            adv_time.pm = ~time_q.pm;
                        end
                    end
                end else begin
                    adv_time.hours = (time_q.hours == HR_W'(HR24_MAX)) ? '0
                                                                       : time_q.hours + HR_W'(1);
                end
            end else begin
                adv_time.minutes = time_q.minutes + MIN_W'(1);
            end
        end else begin
            adv_time.seconds = time_q.seconds + SEC_W'(1);
        end
    end

    always_comb begin
        alarm_match = alarm_en
                   && (adv_time.seconds == '0)
                   && (adv_time.hours == alarm_hours)
                   && (adv_time.minutes == alarm_minutes)
                   && (!IS_12H || (adv_time.pm == alarm_pm));
    end

    // a valid load overrides a coincident tick; an invalid one lets the tick through
    always_comb begin
        time_d     = time_q;
        sec_tick_d = 1'b0;
        alarm_d    = 1'b0;
        load_err_d = load && !load_ok;
        if (load_ok) begin
            time_d = load_time;
        end else if (tick) begin
            time_d     = adv_time;
            sec_tick_d = 1'b1;
            alarm_d    = alarm_match;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            time_q.hours   <= HR_RESET;
            time_q.minutes <= '0;
            time_q.seconds <= '0;
            time_q.pm      <= 1'b0;
            sec_tick_q     <= 1'b0;
            alarm_q        <= 1'b0;
            load_err_q     <= 1'b0;
        end else begin
            time_q     <= time_d;
            sec_tick_q <= sec_tick_d;
            alarm_q    <= alarm_d;
            load_err_q <= load_err_d;
        end
    end

    assign seconds  = time_q.seconds;
    assign minutes  = time_q.minutes;
    assign hours    = time_q.hours;
    assign pm       = time_q.pm;
    assign sec_tick = sec_tick_q;
    assign alarm    = alarm_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_digital_clock_hms.sv
// tb/tb_digital_clock_hms.sv - scoreboard bench for digital_clock_hms in 24h and 12h modes
module tb_digital_clock_hms;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       run24 = 1'b0, run12 = 1'b0, load24 = 1'b0, load12 = 1'b0;
    logic [4:0] lh = '0;
    logic [5:0] lm = '0, ls = '0;
    logic       lpm = 1'b0;
    logic       aen = 1'b0;
    logic [4:0] ah = '0;
    logic [5:0] am = '0;
    logic       apm = 1'b0;

    logic [5:0] s24, m24, s12, m12;
    logic [4:0] h24, h12;
    logic       pm24, st24, al24, er24, pm12, st12, al12, er12;

    digital_clock_hms #(.CLK_PER_SEC(4), .MODE_12H(0)) d24 (
        .clk(clk), .reset(reset), .run(run24), .load(load24),
        .load_hours(lh), .load_minutes(lm), .load_seconds(ls), .load_pm(lpm),
        .alarm_en(aen), .alarm_hours(ah), .alarm_minutes(am), .alarm_pm(apm),
        .seconds(s24), .minutes(m24), .hours(h24), .pm(pm24),
        .sec_tick(st24), .alarm(al24), .load_err(er24)
    );

    digital_clock_hms #(.CLK_PER_SEC(4), .MODE_12H(1)) d12 (
        .clk(clk), .reset(reset), .run(run12), .load(load12),
        .load_hours(lh), .load_minutes(lm), .load_seconds(ls), .load_pm(lpm),
        .alarm_en(aen), .alarm_hours(ah), .alarm_minutes(am), .alarm_pm(apm),
        .seconds(s12), .minutes(m12), .hours(h12), .pm(pm12),
        .sec_tick(st12), .alarm(al12), .load_err(er12)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [4:0]  h;
        logic [5:0]  m;
        logic [5:0]  s;
        logic        pm;
        logic        st;
        logic        al;
        logic        er;
    } ev_t;

    ev_t         q24[$];
    ev_t         q12[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] cyc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(int dly, int h, int m, int s, bit p, bit st, bit al, bit er);
        ev_t e;
        e.cyc = cyc + 32'(dly);
        e.h   = 5'(h);
        e.m   = 6'(m);
        e.s   = 6'(s);
        e.pm  = p;
        e.st  = st;
        e.al  = al;
        e.er  = er;
        return e;
    endfunction

    // monitors: any pulse on a DUT output consumes the next expected event
    always @(negedge clk) begin
        ev_t a, e;
        if (st24 || al24 || er24) begin
            a = '{cyc, h24, m24, s24, pm24, st24, al24, er24};
            total++;
            if (q24.size() == 0) begin
                bad++;
                $display("FAIL ev24 unexpected event got=%h", a);
            end else begin
                e = q24.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL ev24 got cyc=%0d %0d:%0d:%0d pm=%b st=%b al=%b er=%b exp cyc=%0d %0d:%0d:%0d pm=%b st=%b al=%b er=%b",
                             a.cyc, a.h, a.m, a.s, a.pm, a.st, a.al, a.er,
                             e.cyc, e.h, e.m, e.s, e.pm, e.st, e.al, e.er);
                end
            end
        end
        if (st12 || al12 || er12) begin
            a = '{cyc, h12, m12, s12, pm12, st12, al12, er12};
            total++;
            if (q12.size() == 0) begin
                bad++;
                $display("FAIL ev12 unexpected event got=%h", a);
            end else begin
                e = q12.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL ev12 got cyc=%0d %0d:%0d:%0d pm=%b st=%b al=%b er=%b exp cyc=%0d %0d:%0d:%0d pm=%b st=%b al=%b er=%b",
                             a.cyc, a.h, a.m, a.s, a.pm, a.st, a.al, a.er,
                             e.cyc, e.h, e.m, e.s, e.pm, e.st, e.al, e.er);
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic do_load(bit sel12, int h, int m, int s, bit p);
        lh  = 5'(h);
        lm  = 6'(m);
        ls  = 6'(s);
        lpm = p;
        if (sel12) load12 = 1'b1;
        else       load24 = 1'b1;
        step(1);
        load12 = 1'b0;
        load24 = 1'b0;
    endtask

    initial begin
        step(2);
        chk("rst_sec24", 32'(s24), 0);
        chk("rst_min24", 32'(m24), 0);
        chk("rst_hr24", 32'(h24), 0);
        chk("rst_pm24", 32'(pm24), 0);
        chk("rst_pulses24", 32'({st24, al24, er24}), 0);
        chk("rst_hr12", 32'(h12), 12);
        chk("rst_pm12", 32'(pm12), 0);
        chk("rst_pulses12", 32'({st12, al12, er12}), 0);
        reset = 1'b0;

        // reset mid-count must zero the prescaler
        run24 = 1'b1;
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("midrst_sec24", 32'(s24), 0);
        q24.push_back(mk(4, 0, 0, 1, 0, 1, 0, 0));
        step(4);
        run24 = 1'b0;

        // tick spacing and run hold
        run24 = 1'b1;
        q24.push_back(mk(5, 0, 0, 59, 0, 1, 0, 0));
        q24.push_back(mk(9, 0, 1, 0, 0, 1, 0, 0));
        do_load(0, 0, 0, 58, 0);
        step(8);
        step(2);
        run24 = 1'b0;
        step(3);
        chk("hold_sec24", 32'(s24), 0);
        run24 = 1'b1;
        q24.push_back(mk(2, 0, 1, 1, 0, 1, 0, 0));
        step(2);
        run24 = 1'b0;

        // 24h wraps
        run24 = 1'b1;
        q24.push_back(mk(5, 0, 0, 0, 0, 1, 0, 0));
        do_load(0, 23, 59, 59, 0);
        step(4);
        q24.push_back(mk(5, 10, 0, 0, 0, 1, 0, 0));
        do_load(0, 9, 59, 59, 0);
        step(4);
        run24 = 1'b0;

        // rejected loads
        q24.push_back(mk(1, 10, 0, 0, 0, 0, 0, 1));
        do_load(0, 10, 60, 0, 0);
        q24.push_back(mk(1, 10, 0, 0, 0, 0, 0, 1));
        do_load(0, 24, 0, 0, 0);
        run24 = 1'b1;
        step(3);
        q24.push_back(mk(1, 10, 0, 1, 0, 1, 0, 1));
        do_load(0, 10, 0, 60, 0);
        run24 = 1'b0;

        // valid load on a tick edge discards the tick and restarts the phase
        run24 = 1'b1;
        step(3);
        q24.push_back(mk(5, 5, 6, 8, 0, 1, 0, 0));
        do_load(0, 5, 6, 7, 0);
        step(4);
        run24 = 1'b0;

        // alarm
        aen = 1'b1;
        ah  = 5'd0;
        am  = 6'd1;
        apm = 1'b0;
        run24 = 1'b1;
        q24.push_back(mk(5, 0, 1, 0, 0, 1, 1, 0));
        q24.push_back(mk(9, 0, 1, 1, 0, 1, 0, 0));
        do_load(0, 0, 0, 59, 0);
        step(8);
        run24 = 1'b0;
        do_load(0, 0, 1, 0, 0);
        step(3);
        chk("load_min24", 32'(m24), 1);
        aen = 1'b0;
        run24 = 1'b1;
        q24.push_back(mk(5, 0, 1, 0, 0, 1, 0, 0));
        do_load(0, 0, 0, 59, 0);
        step(4);
        run24 = 1'b0;

        // 12h mode
        aen = 1'b1;
        ah  = 5'd12;
        am  = 6'd0;
        apm = 1'b1;
        run12 = 1'b1;
        q12.push_back(mk(5, 12, 0, 0, 1, 1, 1, 0));
        do_load(1, 11, 59, 59, 0);
        step(4);
        aen = 1'b0;
        q12.push_back(mk(5, 1, 0, 0, 1, 1, 0, 0));
        do_load(1, 12, 59, 59, 1);
        step(4);
        run12 = 1'b0;
        q12.push_back(mk(1, 1, 0, 0, 1, 0, 0, 1));
        do_load(1, 0, 0, 0, 0);
        step(3);

        chk("q24_drained", 32'(q24.size()), 0);
        chk("q12_drained", 32'(q12.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
